// File: rtl/mdu_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
package mdu_pkg;

   // M-extension funct7 that routes an R-type instruction to this unit
   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   typedef enum logic [2:0] {
      MUL    = 3'b000,
      MULH   = 3'b001,
      MULHSU = 3'b010,
      MULHU  = 3'b011,
      DIV    = 3'b100,
      DIVU   = 3'b101,
      REM    = 3'b110,
      REMU   = 3'b111
   } mdu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } mdu_state_e;

   // funct3[2] clear selects the multiply group
   function automatic logic is_mul_op(input mdu_op_e op);
      return ~op[2];
   endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Shared radix-2 datapath: one shift-add (multiply) or one restoring
// subtract (divide) per step over a 2*XLEN accumulator {hi, lo}.
// Multiply: hi starts at 0, lo holds the multiplier, m holds the multiplicand;
// after XLEN steps {hi, lo} is the product.
// Divide: hi starts at 0, lo holds the dividend, m holds the divisor;
// after XLEN steps hi is the remainder and lo the quotient.
module mdu_iter_core
   import mdu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic              step_i,
   input  logic              is_mul_i,
   input  logic [XLEN-1:0]   opa_i,
   input  logic [XLEN-1:0]   opb_i,
   output logic [2*XLEN-1:0] acc_nxt_o
);

   logic [2*XLEN-1:0] acc_q, acc_d, acc_step;
   logic [XLEN-1:0]   m_q, m_d;
   logic              mul_q, mul_d;
   logic [XLEN-1:0]   hi, lo;
   logic [XLEN:0]     addend, sum, shifted, diff;

   assign hi = acc_q[2*XLEN-1:XLEN];
   assign lo = acc_q[XLEN-1:0];

   // one iteration of the selected algorithm
   always_comb begin
      addend  = lo[0] ? {1'b0, m_q} : {(XLEN+1){1'b0}};
      sum     = {1'b0, hi} + addend;
      shifted = {hi, lo[XLEN-1]};
      diff    = shifted - {1'b0, m_q};
      if (mul_q) begin
         acc_step = {sum, lo[XLEN-1:1]};
      end else if (!diff[XLEN]) begin
         acc_step = {diff[XLEN-1:0], lo[XLEN-2:0], 1'b1};
      end else begin
         acc_step = {shifted[XLEN-1:0], lo[XLEN-2:0], 1'b0};
      end
   end

   assign acc_nxt_o = acc_step;

   // load on accept, otherwise advance one step while enabled
   always_comb begin
      acc_d = acc_q;
      m_d   = m_q;
      mul_d = mul_q;
      if (load_i) begin
         acc_d = {{XLEN{1'b0}}, (is_mul_i ? opb_i : opa_i)};
         m_d   = is_mul_i ? opa_i : opb_i;
         mul_d = is_mul_i;
      end else if (step_i) begin
         acc_d = acc_step;
      end
   end

   // accumulator and operand registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         m_q   <= '0;
         mul_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         m_q   <= m_d;
         mul_q <= mul_d;
      end
   end

endmodule

// File: rtl/mdu_seq.sv
// Sequential RISC-V M-extension multiply/divide unit.
// Optional macro MDU_FAST_MUL_EN: multiplies use a single-cycle multiplier.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// BUSY  | iterating, one bit per cycle for XLEN cycles
// DONE  | result valid, waiting for out_ready
module mdu_seq
   import mdu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic            kill,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

   mdu_state_e        state_q, state_d;
   mdu_op_e           op_in, op_q;
   logic [CW-1:0]     cnt_q;
   logic              neg_q, neg_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic              out_valid_q, out_valid_d;
   logic              in_ready_q, in_ready_d;

   logic              accept, last_step;
   logic              a_sgn, b_sgn, a_neg, b_neg;
   logic [XLEN-1:0]   a_mag, b_mag;
   logic              div_zero, div_ovf, special, go_fast;
   logic [XLEN-1:0]   special_res, fast_res, final_res;
   logic [2*XLEN-1:0] acc_nxt, prod_fix;
   logic [XLEN-1:0]   div_sel;

   assign op_in     = mdu_op_e'(funct3);
   assign accept    = in_valid && in_ready_q && !kill;
   assign last_step = (state_q == BUSY) && (cnt_q == CNT_LAST);

   // operand magnitudes, result sign and special-case detection at accept
   always_comb begin
      a_sgn    = (op_in == MUL) || (op_in == MULH) || (op_in == MULHSU) ||
                 (op_in == DIV) || (op_in == REM);
      b_sgn    = (op_in == MUL) || (op_in == MULH) || (op_in == DIV) || (op_in == REM);
      a_neg    = a_sgn && op_a[XLEN-1];
      b_neg    = b_sgn && op_b[XLEN-1];
      a_mag    = a_neg ? (~op_a + 1'b1) : op_a;
      b_mag    = b_neg ? (~op_b + 1'b1) : op_b;
      neg_d    = (op_in == REM) ? a_neg : (a_neg ^ b_neg);
      div_zero = !is_mul_op(op_in) && (op_b == '0);
      div_ovf  = ((op_in == DIV) || (op_in == REM)) && (op_a == XMIN) && (op_b == '1);
      special  = div_zero || div_ovf;
      if (div_zero) begin
         special_res = ((op_in == DIV) || (op_in == DIVU)) ? '1 : op_a;
      end else begin
         special_res = (op_in == DIV) ? op_a : '0;
      end
   end

`ifdef MDU_FAST_MUL_EN
   logic [2*XLEN-1:0] ext_a, ext_b, prod;

   // single-cycle product of sign/zero-extended operands
   always_comb begin
      ext_a    = {{XLEN{a_sgn & op_a[XLEN-1]}}, op_a};
      ext_b    = {{XLEN{b_sgn & op_b[XLEN-1]}}, op_b};
      prod     = ext_a * ext_b;
      fast_res = (op_in == MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      go_fast  = is_mul_op(op_in);
   end
`else
   assign fast_res = '0;
   assign go_fast  = 1'b0;
`endif

   mdu_iter_core #(.XLEN(XLEN)) u_core (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (accept),
      .step_i    (state_q == BUSY),
      .is_mul_i  (is_mul_op(op_in)),
      .opa_i     (a_mag),
      .opb_i     (b_mag),
      .acc_nxt_o (acc_nxt)
   );

   // sign fix-up and half/quotient/remainder selection on the final step
   always_comb begin
      prod_fix = neg_q ? (~acc_nxt + 1'b1) : acc_nxt;
      div_sel  = ((op_q == DIV) || (op_q == DIVU)) ? acc_nxt[XLEN-1:0]
                                                   : acc_nxt[2*XLEN-1:XLEN];
      if (is_mul_op(op_q)) begin
         final_res = (op_q == MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
      end else begin
         final_res = neg_q ? (~div_sel + 1'b1) : div_sel;
      end
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // next-state logic; kill overrides every other request
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = (special || go_fast) ? DONE : BUSY;
         BUSY: if (kill) state_d = IDLE;
               else if (cnt_q == CNT_LAST) state_d = DONE;
         DONE: if (kill || out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // handshake outputs decoded from next state, then registered
   always_comb begin
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
      result_d    = result_q;
      if (accept && special)                      result_d = special_res;
      else if (accept && go_fast)                 result_d = fast_res;
      else if (last_step && !kill)                result_d = final_res;
   end

   // registered outputs, captured op and iteration counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         op_q        <= MUL;
         neg_q       <= 1'b0;
         cnt_q       <= '0;
      end else begin
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         if (accept) begin
            op_q  <= op_in;
            neg_q <= neg_d;
            cnt_q <= '0;
         end else if (state_q == BUSY) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;

endmodule
